au_requester: RTL and testbench
===============================

Name: au_requester

Overview:
- Initiator side of the 5-bit arithmetic-unit interface (operands A/B, op select `chave`, outputs `resultado`/`igual`/`diferente`).
- Accepts operation requests over a valid/ready handshake and drives a registered, stable operand set into the combinational AU.
- Waits a programmable settle time, captures the AU outputs, and returns a response over a second valid/ready handshake.
- Adds signed overflow and an AU consistency check to the response.

Parameters:
- WIDTH, 5, operand/result width in bits.
- SETTLE, 1, cycles the operands are held before AU outputs are sampled (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  requester can accept a request.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- req_sub  input  1  0 = add, 1 = subtract.
- au_a  output  WIDTH  registered operand A to AU.
- au_b  output  WIDTH  registered operand B to AU.
- au_chave  output  1  registered op select to AU (1 = subtract).
- au_resultado  input  WIDTH  AU result.
- au_igual  input  1  AU A==B flag.
- au_diferente  input  1  AU A!=B flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  captured result.
- rsp_eq  output  1  captured `igual`.
- rsp_ovf  output  1  signed two's-complement overflow.
- rsp_err  output  1  AU consistency failure.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - req_ready=1, rsp_valid=0.
  - au_a, au_b, au_chave, rsp_result, rsp_eq, rsp_ovf, rsp_err all 0.
  - Settle counter 0.
- FSM states: IDLE, DRIVE, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: register req_a/req_b/req_sub into au_a/au_b/au_chave, load counter=SETTLE-1, go DRIVE.
- DRIVE:
  - req_ready=0; au_* held stable.
  - Counter decrements each cycle; at 0 go CAPTURE.
  - With SETTLE=1, DRIVE lasts exactly 1 cycle.
- CAPTURE (1 cycle):
  - rsp_result <= au_resultado; rsp_eq <= au_igual.
  - Compute rsp_ovf and rsp_err from the held au_a/au_b/au_chave and sampled au_resultado.
  - Go RESP.
- RESP:
  - rsp_valid=1.
  - rsp_* and au_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid drops next cycle and FSM returns to IDLE.
  - No bypass: req_ready is 0 throughout RESP.
- Latency: request accept edge to rsp_valid high = SETTLE+2 cycles.
- Throughput: one operation per SETTLE+3 cycles with rsp_ready tied 1.
- Overflow, with MSB = bit WIDTH-1:
  - add: a[MSB]==b[MSB] && res[MSB]!=a[MSB].
  - sub: a[MSB]!=b[MSB] && res[MSB]!=a[MSB].
- Error: rsp_err=1 if any of the following holds:
  - au_igual == au_diferente.
  - au_igual != (au_a==au_b).
  - chave=1 and (au_resultado==0) != au_igual.
  - au_resultado != (add ? a+b : a-b) mod 2^WIDTH.
- Arithmetic is modulo 2^WIDTH; no carry is reported.
- Boundary conditions:
  - req_valid high while not in IDLE is ignored; requester must hold it until it sees req_ready.
  - req_valid and rsp_ready both high in RESP: response completes; the new request is accepted only after the return to IDLE.
  - rst_n asserted mid-operation: immediate return to reset values; the in-flight request is dropped, no response.
  - SETTLE outside 1..15 is an elaboration error.

Decomposition:
- Shared package au_pkg:
  - AU_WIDTH=5.
  - FSM state enum (IDLE, DRIVE, CAPTURE, RESP).
  - OP_ADD=0, OP_SUB=1 constants.
- One sub-module: au_checker.
  - Combinational; inputs a, b, chave, resultado, igual, diferente.
  - Outputs ovf, err.
  - Reusable by other AU consumers.

Test Plan:
- Add: a=5'b10101, b=5'b01110, sub=0 -> rsp_result=5'b00011, eq=0, ovf=0, err=0, rsp_valid at accept+3 cycles (SETTLE=1).
- Sub equal: a=b=5'b01111, sub=1 -> rsp_result=0, eq=1, ovf=0, err=0.
- Overflow:
  - a=5'b01111, b=5'b00001, add -> result=5'b10000, ovf=1.
  - a=5'b10000, b=5'b00001, sub -> result=5'b01111, ovf=1.
  - a=0, b=1, sub -> result=5'b11111, ovf=0.
- Faulty AU model: resultado stuck at 0, a=3, b=4, add -> err=1. Separately: igual=diferente=1 -> err=1.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_*, au_* stable, req_ready=0; a second req_valid during this window is not accepted until the cycle after the RESP handshake.
- Reset mid-operation: drop rst_n during DRIVE -> rsp_valid=0, au_*=0, req_ready=1 immediately; the next request completes normally.

Source files
------------

// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared constants and types for the arithmetic-unit requester
//
// Purpose: common width, op-select encoding, FSM state type and settle
//          counter width used by au_requester and au_checker.
// Ports:   none (package).

package au_pkg;

  localparam int AU_WIDTH = 5;
  localparam int CNT_W    = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/au_checker.sv
// rtl/au_checker.sv - combinational overflow and consistency check of an AU result
//
// Purpose: derives signed overflow from the operands and result, and flags
//          any AU output that disagrees with the arithmetic it was asked for.
// Ports:   a, b       operands as presented to the AU
//          chave      op select (OP_SUB = subtract)
//          resultado  AU result
//          igual      AU equality flag
//          diferente  AU inequality flag
//          ovf        signed two's-complement overflow
//          err        AU outputs inconsistent

module au_checker
  import au_pkg::*;
#(
  parameter int WIDTH = AU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             chave,
  input  logic [WIDTH-1:0] resultado,
  input  logic             igual,
  input  logic             diferente,
  output logic             ovf,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_expect;
  logic             w_is_sub;
  logic             w_eq_ab;
  logic             w_res_zero;

  assign w_is_sub   = (chave == OP_SUB);
  assign w_expect   = w_is_sub ? (a - b) : (a + b);
  assign w_eq_ab    = (a == b);
  assign w_res_zero = (resultado == '0);

  // Overflow happens when the result sign disagrees with operand A while the
  // effective operand signs agree (for subtract, B's sign is inverted).
  always_comb begin
    ovf = 1'b0;
    if (w_is_sub) begin
      ovf = (a[MSB] != b[MSB]) && (resultado[MSB] != a[MSB]);
    end else begin
      ovf = (a[MSB] == b[MSB]) && (resultado[MSB] != a[MSB]);
    end
  end

  // A subtract result of zero must coincide with the equality flag.
  always_comb begin
    err = 1'b0;
    if (igual == diferente)                   err = 1'b1;
    if (igual != w_eq_ab)                     err = 1'b1;
    if (w_is_sub && (w_res_zero != igual))    err = 1'b1;
    if (resultado != w_expect)                err = 1'b1;
  end

endmodule

// File: rtl/au_requester.sv
// rtl/au_requester.sv - initiator driving a combinational AU over request/response handshakes
//
// Purpose: accepts an operation, holds registered operands on the AU for
//          SETTLE cycles, captures the AU outputs with overflow and
//          consistency status, and presents them as a response.
// Ports:   clk, rst_n                       clock, async active-low reset
//          req_valid/req_ready              request handshake
//          req_a, req_b, req_sub            request operands and op
//          au_a, au_b, au_chave             registered operands to AU
//          au_resultado, au_igual,
//          au_diferente                     AU outputs
//          rsp_valid/rsp_ready              response handshake
//          rsp_result, rsp_eq, rsp_ovf,
//          rsp_err                          captured response

module au_requester
  import au_pkg::*;
#(
  parameter int WIDTH  = AU_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic             au_chave,
  input  logic [WIDTH-1:0] au_resultado,
  input  logic             au_igual,
  input  logic             au_diferente,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_eq,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("au_requester: SETTLE must be in 1..15");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_ovf;
  logic             w_err;

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign w_accept  = req_valid && req_ready;

  au_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .a         (au_a),
    .b         (au_b),
    .chave     (au_chave),
    .resultado (au_resultado),
    .igual     (au_igual),
    .diferente (au_diferente),
    .ovf       (w_ovf),
    .err       (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)         w_next = DRIVE;
      DRIVE:   if (r_cnt == '0)      w_next = CAPTURE;
      CAPTURE:                       w_next = RESP;
      RESP:    if (rsp_ready)        w_next = IDLE;
      default:                       w_next = IDLE;
    endcase
  end

  // Operands are only loaded on acceptance, so they stay stable on the AU
  // through DRIVE, CAPTURE and the whole response phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      au_a       <= '0;
      au_b       <= '0;
      au_chave   <= 1'b0;
      r_cnt      <= '0;
      rsp_result <= '0;
      rsp_eq     <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        au_a     <= req_a;
        au_b     <= req_b;
        au_chave <= req_sub;
        r_cnt    <= CNT_W'(SETTLE - 1);
      end
      if (r_state == DRIVE && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == CAPTURE) begin
        rsp_result <= au_resultado;
        rsp_eq     <= au_igual;
        rsp_ovf    <= w_ovf;
        rsp_err    <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_au_requester.sv
// tb/tb_au_requester.sv - self-checking bench for au_requester with a behavioural AU

module tb_au_requester;

  localparam int W      = 5;
  localparam int SETTLE = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_sub = 1'b0;
  logic [W-1:0] au_a;
  logic [W-1:0] au_b;
  logic         au_chave;
  logic [W-1:0] au_resultado;
  logic         au_igual;
  logic         au_diferente;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_eq;
  logic         rsp_ovf;
  logic         rsp_err;

  int total = 0;
  int bad   = 0;
  int fault = 0;   // 0 = good AU, 1 = result stuck at 0, 2 = igual=diferente=1

  always #5 clk = ~clk;

  au_requester #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .au_a         (au_a),
    .au_b         (au_b),
    .au_chave     (au_chave),
    .au_resultado (au_resultado),
    .au_igual     (au_igual),
    .au_diferente (au_diferente),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_eq       (rsp_eq),
    .rsp_ovf      (rsp_ovf),
    .rsp_err      (rsp_err)
  );

  // Reference: AU outputs (with optional fault), true signed overflow from
  // integer arithmetic, and error = "AU output differs from the ideal AU".
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input int fm,
                                output logic [W-1:0] res, output logic eq,
                                output logic dif, output logic ovf,
                                output logic err);
    int sa, sb, st, ua, ub;
    logic [W-1:0] ideal;
    logic         ieq;
    ua = int'(a);
    ub = int'(b);
    ideal = W'(sub ? (ua - ub + 32) % 32 : (ua + ub) % 32);
    ieq   = (ua == ub);
    res = ideal;
    eq  = ieq;
    dif = !ieq;
    if (fm == 1) res = '0;
    if (fm == 2) begin eq = 1'b1; dif = 1'b1; end
    sa  = (ua >= 16) ? ua - 32 : ua;
    sb  = (ub >= 16) ? ub - 32 : ub;
    st  = sub ? sa - sb : sa + sb;
    ovf = (st > 15) || (st < -16);
    err = (res != ideal) || (eq != ieq) || (dif != !ieq);
  endfunction

  logic m_ovf, m_err;
  always_comb begin
    model(au_a, au_b, au_chave, fault, au_resultado, au_igual, au_diferente, m_ovf, m_err);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_rsp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input int fm);
    logic [W-1:0] e_res;
    logic e_eq, e_dif, e_ovf, e_err;
    model(a, b, sub, fm, e_res, e_eq, e_dif, e_ovf, e_err);
    check({tag, "_valid"},  32'(rsp_valid), 32'd1);
    check({tag, "_result"}, 32'(rsp_result), 32'(e_res));
    check({tag, "_eq"},     32'(rsp_eq), 32'(e_eq));
    check({tag, "_err"},    32'(rsp_err), 32'(e_err));
    if (fm == 0) check({tag, "_ovf"}, 32'(rsp_ovf), 32'(e_ovf));
    check({tag, "_au_a"},   32'(au_a), 32'(a));
    check({tag, "_au_b"},   32'(au_b), 32'(b));
    check({tag, "_rdy"},    32'(req_ready), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input int fm);
    int n;
    fault = fm;
    req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
    check({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    check({tag, "_latency"}, 32'(n), 32'(SETTLE + 2));
    check_rsp(tag, a, b, sub, fm);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_post"}, 32'(req_ready), 32'd1);
  endtask

  logic [W-1:0] s_res, s_a, s_b;
  logic         s_eq, s_ovf, s_err, s_ch;
  int           n;

  initial begin
    // reset state
    #12;
    check("rst_ready",  32'(req_ready), 32'd1);
    check("rst_valid",  32'(rsp_valid), 32'd0);
    check("rst_au_a",   32'(au_a), 32'd0);
    check("rst_au_b",   32'(au_b), 32'd0);
    check("rst_chave",  32'(au_chave), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_flags",  32'({rsp_eq, rsp_ovf, rsp_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // directed cases
    run_op("add",      5'b10101, 5'b01110, 1'b0, 0);
    check("add_res_const", 32'(rsp_result), 32'b00011);
    run_op("sub_eq",   5'b01111, 5'b01111, 1'b1, 0);
    run_op("ovf_add",  5'b01111, 5'b00001, 1'b0, 0);
    check("ovf_add_flag", 32'(rsp_ovf), 32'd1);
    run_op("ovf_sub",  5'b10000, 5'b00001, 1'b1, 0);
    check("ovf_sub_flag", 32'(rsp_ovf), 32'd1);
    run_op("sub_neg",  5'b00000, 5'b00001, 1'b1, 0);
    check("sub_neg_res", 32'(rsp_result), 32'b11111);
    run_op("stuck0",   5'd3, 5'd4, 1'b0, 1);
    check("stuck0_err", 32'(rsp_err), 32'd1);
    run_op("eqdif",    5'd9, 5'd2, 1'b0, 2);
    check("eqdif_err", 32'(rsp_err), 32'd1);

    // backpressure with a competing request
    fault = 0;
    req_a = 5'd7; req_b = 5'd12; req_sub = 1'b1; req_valid = 1'b1;
    tick();
    req_a = 5'd21; req_b = 5'd6; req_sub = 1'b0;   // second request, held
    wait_rsp(n);
    check("bp_latency", 32'(n), 32'(SETTLE + 2));
    check_rsp("bp", 5'd7, 5'd12, 1'b1, 0);
    s_res = rsp_result; s_eq = rsp_eq; s_ovf = rsp_ovf; s_err = rsp_err;
    s_a = au_a; s_b = au_b; s_ch = au_chave;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_rsp",   32'({rsp_result, rsp_eq, rsp_ovf, rsp_err}),
                             32'({s_res, s_eq, s_ovf, s_err}));
      check("bp_hold_au",    32'({au_a, au_b, au_chave}), 32'({s_a, s_b, s_ch}));
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_drop",       32'(rsp_valid), 32'd0);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_not_taken",  32'(au_a), 32'd7);
    tick();
    req_valid = 1'b0;
    check("bp_taken_a", 32'(au_a), 32'd21);
    check("bp_taken_b", 32'(au_b), 32'd6);
    wait_rsp(n);
    check("bp2_latency", 32'(n - 1), 32'(SETTLE + 1));
    check_rsp("bp2", 5'd21, 5'd6, 1'b0, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // reset mid-operation
    req_a = 5'd13; req_b = 5'd5; req_sub = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("mid_drive", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(rsp_valid), 32'd0);
    check("mid_au",    32'({au_a, au_b, au_chave}), 32'd0);
    check("mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_op("after_rst", 5'd13, 5'd5, 1'b1, 0);

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      int fm;
      ra = W'($urandom_range(31, 0));
      rb = W'($urandom_range(31, 0));
      if (i % 5 == 0) rb = ra;
      rs = 1'($urandom_range(1, 0));
      fm = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
      run_op("rand", ra, rb, rs, fm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
